// File: rtl/ysyx_24100005_fetch_ctrl_if.sv
// Fetch-controller bus: instruction-memory request/response plus the execute-stage handshake.
// master = fetch controller, slave = memory / execute side.
interface ysyx_24100005_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_inst;

  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] link_addr;
  logic            exec_done;
  logic [XLEN-1:0] rs1data;
  logic            branch_taken;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_inst,
    output inst_valid,
    output inst,
    output pc,
    output link_addr,
    input  exec_done,
    input  rs1data,
    input  branch_taken
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_inst,
    input  inst_valid,
    input  inst,
    input  pc,
    input  link_addr,
    output exec_done,
    output rs1data,
    output branch_taken
  );
endinterface

// File: rtl/ysyx_24100005_fetch_ctrl.sv
// Fetch / next-PC controller: FETCH -> WAIT -> EXEC loop, halts on EBREAK until reset.
// Optional macro YSYX_24100005_MISALIGN_TRAP_EN adds a fault output that traps misaligned next_pc.
module ysyx_24100005_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic clk,
  input  logic rst,
  ysyx_24100005_fetch_ctrl_if.master bus,
`ifdef YSYX_24100005_MISALIGN_TRAP_EN
  output logic fault,
`endif
  output logic halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [31:0]     EBREAK    = 32'h0010_0073;
  localparam logic [6:0]      OP_JAL    = 7'b1101111;
  localparam logic [6:0]      OP_JALR   = 7'b1100111;
  localparam logic [6:0]      OP_BRANCH = 7'b1100011;
  localparam logic [XLEN-1:0] FOUR      = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_CLR   = {{(XLEN-1){1'b1}}, 1'b0};

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;

  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_i, imm_j, imm_b;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;

`ifdef YSYX_24100005_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
`ifdef YSYX_24100005_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
`ifdef YSYX_24100005_MISALIGN_TRAP_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Immediates are decoded from the captured instruction, so next_pc only
  // depends on registered state plus the execute-stage operands.
  always_comb begin
    opcode = inst_q[6:0];
    imm_i  = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};
    imm_j  = {{(XLEN-21){inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
              inst_q[30:21], 1'b0};
    imm_b  = {{(XLEN-13){inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
              inst_q[11:8], 1'b0};
    seq_pc = pc_q + FOUR;
    case (opcode)
      OP_JAL:    next_pc = pc_q + imm_j;
      OP_JALR:   next_pc = (bus.rs1data + imm_i) & LSB_CLR;
      OP_BRANCH: next_pc = bus.branch_taken ? (pc_q + imm_b) : seq_pc;
      default:   next_pc = seq_pc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
`ifdef YSYX_24100005_MISALIGN_TRAP_EN
    fault_d = fault_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (bus.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          inst_d  = bus.imem_resp_inst;
          state_d = (bus.imem_resp_inst == EBREAK) ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.exec_done) begin
`ifdef YSYX_24100005_MISALIGN_TRAP_EN
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
`else
          pc_d    = {next_pc[XLEN-1:2], 2'b00};
          state_d = S_FETCH;
`endif
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // The reset state is FETCH, so the request is masked while rst is held.
  always_comb begin
    bus.imem_req_valid = (state_q == S_FETCH) && !rst;
    bus.imem_req_addr  = pc_q;
    bus.inst_valid     = (state_q == S_EXEC);
    bus.inst           = inst_q;
    bus.pc             = pc_q;
    bus.link_addr      = seq_pc;
    halted             = (state_q == S_HALT);
`ifdef YSYX_24100005_MISALIGN_TRAP_EN
    fault              = fault_q;
`endif
  end

endmodule

// File: tb/tb_ysyx_24100005_fetch_ctrl.sv
// Scoreboard bench for ysyx_24100005_fetch_ctrl: expected fetch addresses are queued
// when execution is retired and checked at each request handshake.
module tb_ysyx_24100005_fetch_ctrl;
  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] ADDI   = 32'h0010_0093;

  logic clk;
  logic rst;
  logic halted;
`ifdef YSYX_24100005_MISALIGN_TRAP_EN
  logic fault;
`endif

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  ysyx_24100005_fetch_ctrl_if #(.XLEN(XLEN)) ifc ();

  ysyx_24100005_fetch_ctrl #(
    .XLEN    (XLEN),
    .RESET_PC(RST_PC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (ifc.master),
`ifdef YSYX_24100005_MISALIGN_TRAP_EN
    .fault (fault),
`endif
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request monitor: every accepted fetch must match the next queued address.
  always @(negedge clk) begin
    logic [31:0] exp_addr;
    if (!rst && ifc.imem_req_valid && ifc.imem_req_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL req_unexpected addr=%h required=no request", ifc.imem_req_addr);
      end else begin
        exp_addr = exp_q.pop_front();
        if (ifc.imem_req_addr !== exp_addr) begin
          failures++;
          $display("FAIL req_addr got=%h required=%h", ifc.imem_req_addr, exp_addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to_exec(input logic [31:0] instr, input logic [31:0] exp_pc,
                            input int ready_delay, input int resp_delay, input bit stray);
    for (int i = 0; i < ready_delay; i++) begin
      ifc.imem_req_ready  = 1'b0;
      ifc.exec_done       = stray;
      ifc.imem_resp_valid = stray;
      ifc.imem_resp_inst  = 32'hDEAD_BEEF;
      tick();
      checks++;
      if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== exp_pc || ifc.inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_fetch valid=%b addr=%h inst_valid=%b required 1/%h/0",
                 ifc.imem_req_valid, ifc.imem_req_addr, ifc.inst_valid, exp_pc);
      end
    end
    ifc.exec_done       = 1'b0;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_req_ready  = 1'b1;
    tick();
    ifc.imem_req_ready  = 1'b0;
    for (int j = 0; j < resp_delay; j++) begin
      tick();
      checks++;
      if (ifc.inst_valid !== 1'b0 || ifc.imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_wait inst_valid=%b req_valid=%b required 0/0",
                 ifc.inst_valid, ifc.imem_req_valid);
      end
    end
    ifc.imem_resp_valid = 1'b1;
    ifc.imem_resp_inst  = instr;
    tick();
    ifc.imem_resp_valid = 1'b0;
  endtask

  task automatic check_exec(input logic [31:0] instr, input logic [31:0] exp_pc);
    checks++;
    if (ifc.inst_valid !== 1'b1 || ifc.inst !== instr || ifc.pc !== exp_pc ||
        ifc.link_addr !== exp_pc + 32'd4) begin
      failures++;
      $display("FAIL exec_view valid=%b inst=%h pc=%h link=%h required 1/%h/%h/%h",
               ifc.inst_valid, ifc.inst, ifc.pc, ifc.link_addr, instr, exp_pc, exp_pc + 32'd4);
    end
  endtask

  task automatic finish_exec(input logic [31:0] rs1, input bit taken, input logic [31:0] exp_next);
    exp_q.push_back(exp_next);
    ifc.exec_done    = 1'b1;
    ifc.rs1data      = rs1;
    ifc.branch_taken = taken;
    tick();
    ifc.exec_done    = 1'b0;
    ifc.branch_taken = 1'b0;
    checks++;
    if (ifc.inst_valid !== 1'b0 || ifc.imem_req_valid !== 1'b1 || ifc.pc !== exp_next) begin
      failures++;
      $display("FAIL next_pc inst_valid=%b req_valid=%b pc=%h required 0/1/%h",
               ifc.inst_valid, ifc.imem_req_valid, ifc.pc, exp_next);
    end
  endtask

  task automatic run_instr(input logic [31:0] instr, input logic [31:0] exp_pc,
                           input logic [31:0] rs1, input bit taken, input logic [31:0] exp_next);
    go_to_exec(instr, exp_pc, 0, 0, 1'b0);
    check_exec(instr, exp_pc);
    finish_exec(rs1, taken, exp_next);
  endtask

  task automatic check_in_reset(input string name);
    checks++;
    if (ifc.pc !== RST_PC || halted !== 1'b0 || ifc.inst_valid !== 1'b0 ||
        ifc.imem_req_valid !== 1'b0 || ifc.inst !== 32'h0) begin
      failures++;
      $display("FAIL %s pc=%h halted=%b inst_valid=%b req_valid=%b inst=%h required %h/0/0/0/0",
               name, ifc.pc, halted, ifc.inst_valid, ifc.imem_req_valid, ifc.inst, RST_PC);
    end
`ifdef YSYX_24100005_MISALIGN_TRAP_EN
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL %s_fault got=%b required=0", name, fault);
    end
`endif
  endtask

  task automatic release_reset();
    tick();
    rst = 1'b0;
    exp_q.push_back(RST_PC);
    #1;
    checks++;
    if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== RST_PC) begin
      failures++;
      $display("FAIL first_req valid=%b addr=%h required 1/%h",
               ifc.imem_req_valid, ifc.imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    check_in_reset("reset_state");
    release_reset();
  endtask

  task automatic test_sequential();
    run_instr(ADDI, 32'h8000_0000, '0, 1'b0, 32'h8000_0004);
    run_instr(ADDI, 32'h8000_0004, '0, 1'b0, 32'h8000_0008);
    run_instr(ADDI, 32'h8000_0008, '0, 1'b0, 32'h8000_000C);
  endtask

  task automatic test_ebreak();
    go_to_exec(32'h0010_0073, 32'h8000_000C, 0, 0, 1'b0);
    checks++;
    if (halted !== 1'b1 || ifc.inst_valid !== 1'b0 || ifc.imem_req_valid !== 1'b0 ||
        ifc.pc !== 32'h8000_000C) begin
      failures++;
      $display("FAIL ebreak halted=%b inst_valid=%b req_valid=%b pc=%h required 1/0/0/8000000c",
               halted, ifc.inst_valid, ifc.imem_req_valid, ifc.pc);
    end
    ifc.imem_req_ready = 1'b1;
    ifc.exec_done      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || ifc.inst_valid !== 1'b0 || ifc.imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold halted=%b inst_valid=%b req_valid=%b required 1/0/0",
                 halted, ifc.inst_valid, ifc.imem_req_valid);
      end
    end
    ifc.imem_req_ready = 1'b0;
    ifc.exec_done      = 1'b0;
  endtask

  task automatic async_reset_now(input string name);
    #2;
    rst = 1'b1;
    #1;
    check_in_reset(name);
    exp_q.delete();
    release_reset();
  endtask

  task automatic test_reset_in_halt();
    async_reset_now("reset_in_halt");
  endtask

  task automatic test_control_flow();
    go_to_exec(32'h0100_006F, 32'h8000_0000, 0, 0, 1'b0);
    check_exec(32'h0100_006F, 32'h8000_0000);
    finish_exec('0, 1'b0, 32'h8000_0010);
    run_instr(32'h0000_0067, 32'h8000_0010, 32'h8000_0101, 1'b0, 32'h8000_0100);
    run_instr(32'h0000_0067, 32'h8000_0100, 32'h8000_0020, 1'b0, 32'h8000_0020);
    run_instr(32'hFE00_0CE3, 32'h8000_0020, '0, 1'b1, 32'h8000_0018);
    run_instr(32'h0080_006F, 32'h8000_0018, '0, 1'b0, 32'h8000_0020);
    run_instr(32'hFE00_0CE3, 32'h8000_0020, '0, 1'b0, 32'h8000_0024);
  endtask

  task automatic test_back_pressure();
    go_to_exec(ADDI, 32'h8000_0024, 4, 3, 1'b1);
    check_exec(ADDI, 32'h8000_0024);
    finish_exec('0, 1'b0, 32'h8000_0028);
  endtask

  task automatic test_reset_in_exec();
    go_to_exec(ADDI, 32'h8000_0028, 0, 0, 1'b0);
    check_exec(ADDI, 32'h8000_0028);
    async_reset_now("reset_in_exec");
  endtask

  task automatic test_misalign();
    go_to_exec(32'h0000_0067, RST_PC, 0, 0, 1'b0);
    check_exec(32'h0000_0067, RST_PC);
`ifdef YSYX_24100005_MISALIGN_TRAP_EN
    ifc.exec_done = 1'b1;
    ifc.rs1data   = 32'h8000_0006;
    tick();
    ifc.exec_done = 1'b0;
    ifc.imem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (halted !== 1'b1 || fault !== 1'b1 || ifc.pc !== RST_PC || ifc.imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL misalign_trap halted=%b fault=%b pc=%h req_valid=%b required 1/1/%h/0",
                 halted, fault, ifc.pc, ifc.imem_req_valid, RST_PC);
      end
      tick();
    end
    ifc.imem_req_ready = 1'b0;
`else
    finish_exec(32'h8000_0006, 1'b0, 32'h8000_0004);
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready = 1'b0;
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst                 = 1'b1;
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_inst  = '0;
    ifc.exec_done       = 1'b0;
    ifc.rs1data         = '0;
    ifc.branch_taken    = 1'b0;

    test_reset();
    test_sequential();
    test_ebreak();
    test_reset_in_halt();
    test_control_flow();
    test_back_pressure();
    test_reset_in_exec();
    test_misalign();

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL req_missing pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout reached=%0t required=finish earlier", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
